associate: RTL and testbench

ASSOCIATE -- requirements
Module: associate

---
 rtl/associate_pkg.sv | 26 ++
 rtl/associate_mac.sv | 38 +++
 rtl/associate.sv | 125 ++++++++++++
 tb/tb_associate.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/associate_pkg.sv
// Shared fixed-point widths, saturation helper and FSM state type for the
// associate neuron.
package associate_pkg;

  localparam int WGTW = 16;
  localparam int FRAC = 8;
  localparam int ACCW = 64;

  localparam logic signed [ACCW-1:0] SAT_MAX = 64'sd32767;
  localparam logic signed [ACCW-1:0] SAT_MIN = -64'sd32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RES  = 2'd1,
    FBK  = 2'd2
  } state_t;

  function automatic logic signed [WGTW-1:0] sat16(input logic signed [ACCW-1:0] v);
    logic signed [WGTW-1:0] r;
    if (v > SAT_MAX)      r = 16'sh7fff;
    else if (v < SAT_MIN) r = 16'sh8000;
    else                  r = v[WGTW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/associate_mac.sv
// Signed dot product of N element pairs, arithmetic right shift, offset add
// and saturation to 16 bits; purely combinational.
module associate_mac
  import associate_pkg::*;
#(
  parameter int N     = 2,
  parameter int AW    = 16,
  parameter int BW    = 9,
  parameter int SHIFT = FRAC
) (
  input  logic [N*AW-1:0]        a,
  input  logic [N*BW-1:0]        b,
  input  logic signed [WGTW-1:0] offset,
  output logic signed [WGTW-1:0] y
);

  localparam int PW = AW + BW;
  localparam int SW = PW + $clog2(N) + 1;

  logic signed [PW-1:0] prod [N];
  logic signed [SW-1:0] sum;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_prod
      assign prod[gi] = PW'($signed(a[gi*AW +: AW])) * PW'($signed(b[gi*BW +: BW]));
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + SW'(prod[i]);
  end

  // The shift happens on the full-precision sum, before the offset is added.
  assign y = sat16(ACCW'(sum >>> SHIFT) + ACCW'(offset));

endmodule

// File: rtl/associate.sv
// Trainable single neuron: forward dot product plus bias, backward feedback
// through the weights, and an error-driven weight/bias update.
module associate
  import associate_pkg::*;
#(
  parameter int ARGN = 2,
  parameter int ARGW = 8,
  parameter int RESW = 16,
  parameter int ERRW = 16,
  parameter int FBKW = 16,
  parameter int RATE = 1,
  localparam int FBKN = ARGN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [ARGN*ARGW-1:0]   arg,
  input  logic                   arg_valid,
  output logic                   arg_ready,
  output logic [RESW-1:0]        res,
  output logic                   res_valid,
  input  logic                   res_ready,
  input  logic signed [ERRW-1:0] err,
  input  logic                   err_valid,
  output logic                   err_ready,
  output logic [FBKN*FBKW-1:0]   fbk,
  output logic                   fbk_valid,
  input  logic                   fbk_ready
);

  state_t state_reg, state_next;

  logic [ARGN*ARGW-1:0]     arg_reg;
  logic signed [WGTW-1:0]   weights [ARGN];
  logic signed [WGTW-1:0]   bias;
  logic signed [WGTW-1:0]   weights_next [ARGN];
  logic signed [WGTW-1:0]   bias_next;
  logic signed [WGTW-1:0]   fwd_y;
  logic signed [WGTW-1:0]   fbk_y [ARGN];
  logic signed [WGTW-1:0]   dlt_y [ARGN];
  logic [ARGN*WGTW-1:0]     wvec;
  logic [ARGN*(ARGW+1)-1:0] arg_ext;
  logic [ARGN*(ARGW+1)-1:0] lat_ext;
  logic [FBKN*FBKW-1:0]     fbk_next;
  logic                     arg_fire;
  logic                     err_fire;

  // Arguments are unsigned fractions, so each gets a zero sign bit.
  genvar gi;
  generate
    for (gi = 0; gi < ARGN; gi++) begin : g_elem
      assign wvec[gi*WGTW +: WGTW]           = weights[gi];
      assign arg_ext[gi*(ARGW+1) +: ARGW+1] = {1'b0, arg[gi*ARGW +: ARGW]};
      assign lat_ext[gi*(ARGW+1) +: ARGW+1] = {1'b0, arg_reg[gi*ARGW +: ARGW]};

      associate_mac #(.N(1), .AW(WGTW), .BW(ERRW), .SHIFT(FRAC)) u_fbk (
        .a(weights[gi]), .b(err), .offset('0), .y(fbk_y[gi])
      );

      associate_mac #(.N(1), .AW(ERRW), .BW(ARGW+1), .SHIFT(FRAC+RATE)) u_dlt (
        .a(err), .b(lat_ext[gi*(ARGW+1) +: ARGW+1]), .offset('0), .y(dlt_y[gi])
      );

      assign weights_next[gi]           = sat16(ACCW'(weights[gi]) + ACCW'(dlt_y[gi]));
      assign fbk_next[gi*FBKW +: FBKW]  = FBKW'(fbk_y[gi]);
    end
  endgenerate

  associate_mac #(.N(ARGN), .AW(WGTW), .BW(ARGW+1), .SHIFT(FRAC)) u_fwd (
    .a(wvec), .b(arg_ext), .offset(bias), .y(fwd_y)
  );

  assign bias_next = sat16(ACCW'(bias) + ACCW'(err >>> RATE));

  // Error wins over a simultaneous argument; the argument waits in IDLE.
  assign err_fire  = (state_reg == IDLE) && err_valid;
  assign arg_fire  = (state_reg == IDLE) && arg_valid && !err_valid;
  assign res_valid = (state_reg == RES);
  assign fbk_valid = (state_reg == FBK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    arg_ready  = 1'b0;
    err_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        err_ready = 1'b1;
        arg_ready = !err_valid;
        if (err_valid)      state_next = FBK;
        else if (arg_valid) state_next = RES;
      end
      RES:     if (res_ready) state_next = IDLE;
      FBK:     if (fbk_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arg_reg <= '0;
      bias    <= '0;
      res     <= '0;
      fbk     <= '0;
      for (int i = 0; i < ARGN; i++) weights[i] <= '0;
    end else begin
      if (arg_fire) begin
        arg_reg <= arg;
        res     <= RESW'(fwd_y);
      end
      if (err_fire) begin
        fbk <= fbk_next;
        if (en) begin
          bias <= bias_next;
          for (int i = 0; i < ARGN; i++) weights[i] <= weights_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_associate.sv
// Scoreboard bench for associate: stimulus queues expected responses, a
// negedge monitor pops and compares them on every output transfer.
module tb_associate;

  localparam int RATE = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [15:0]       arg = '0;
  logic              arg_valid = 1'b0;
  logic              arg_ready;
  logic [15:0]       res;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic signed [15:0] err = '0;
  logic              err_valid = 1'b0;
  logic              err_ready;
  logic [31:0]       fbk;
  logic              fbk_valid;
  logic              fbk_ready = 1'b1;

  logic [15:0] exp_res [$];
  logic [31:0] exp_fbk [$];
  int vectors = 0;
  int miscompares = 0;
  logic signed [15:0] last_res = '0;

  int mw [2];
  int mb;

  associate #(.ARGN(2), .ARGW(8), .RESW(16), .ERRW(16), .FBKW(16), .RATE(RATE)) dut (
    .clk(clk), .rst(rst), .en(en),
    .arg(arg), .arg_valid(arg_valid), .arg_ready(arg_ready),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .err(err), .err_valid(err_valid), .err_ready(err_ready),
    .fbk(fbk), .fbk_valid(fbk_valid), .fbk_ready(fbk_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Monitor: one comparison per output transfer.
  initial begin
    logic [15:0] er;
    logic [31:0] ef;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL res_unexpected: got %h required none", res);
        end else begin
          er = exp_res.pop_front();
          last_res = res;
          chk("res", {16'h0, res}, {16'h0, er});
        end
      end
      if (fbk_valid && fbk_ready) begin
        if (exp_fbk.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL fbk_unexpected: got %h required none", fbk);
        end else begin
          ef = exp_fbk.pop_front();
          chk("fbk", fbk, ef);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    exp_res.delete();
    exp_fbk.delete();
    mw[0] = 0; mw[1] = 0; mb = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_arg(input logic [15:0] a, input logic [15:0] e);
    int n = 0;
    arg = a;
    arg_valid = 1'b1;
    @(negedge clk);
    while (!arg_ready && n < 50) begin n++; @(negedge clk); end
    if (!arg_ready) timeout("arg_handshake");
    else exp_res.push_back(e);
    @(posedge clk);
    #1 arg_valid = 1'b0;
  endtask

  task automatic do_err(input logic signed [15:0] e, input logic [31:0] f);
    int n = 0;
    err = e;
    err_valid = 1'b1;
    @(negedge clk);
    while (!err_ready && n < 50) begin n++; @(negedge clk); end
    if (!err_ready) timeout("err_handshake");
    else exp_fbk.push_back(f);
    @(posedge clk);
    #1 err_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_res.size() != 0 || exp_fbk.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      timeout("response");
      exp_res.delete();
      exp_fbk.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int model_res(input int a0, input int a1);
    return clamp16(((mw[0] * a0 + mw[1] * a1) >>> 8) + mb);
  endfunction

  task automatic train_step(input int a0, input int a1, input int tgt);
    int r, act, e;
    logic [31:0] f;
    r = model_res(a0, a1);
    do_arg({a1[7:0], a0[7:0]}, r[15:0]);
    wait_done();
    act = (r < 0) ? 0 : 255;
    e = tgt - act;
    f[15:0]  = 16'(clamp16((e * mw[0]) >>> 8));
    f[31:16] = 16'(clamp16((e * mw[1]) >>> 8));
    do_err(e[15:0], f);
    wait_done();
    mw[0] = clamp16(mw[0] + clamp16((e * a0) >>> (8 + RATE)));
    mw[1] = clamp16(mw[1] + clamp16((e * a1) >>> (8 + RATE)));
    mb    = clamp16(mb + (e >>> RATE));
  endtask

  task automatic train_and_check(input string name, input int t0, input int t1,
                                 input int t2, input int t3);
    int av [4];
    int tv [4];
    int r;
    av = '{16'h0000, 16'h00ff, 16'hff00, 16'hffff};
    tv = '{t0, t1, t2, t3};
    do_reset();
    en = 1'b1;
    for (int ep = 0; ep < 25; ep++)
      for (int k = 0; k < 4; k++)
        train_step(av[k] & 255, (av[k] >> 8) & 255, tv[k]);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r = model_res(av[k] & 255, (av[k] >> 8) & 255);
      do_arg(av[k][15:0], r[15:0]);
      wait_done();
      chk(name, (last_res < 0) ? 32'd0 : 32'd255, tv[k]);
    end
  endtask

  initial begin
    int n;
    // Reset state
    do_reset();
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_fbk_valid", {31'b0, fbk_valid}, 0);
    chk("rst_arg_ready", {31'b0, arg_ready}, 1);
    chk("rst_err_ready", {31'b0, err_ready}, 1);
    chk("rst_res", {16'h0, res}, 0);
    chk("rst_fbk", fbk, 0);

    // Zero argument through zero weights
    do_arg(16'h0000, 16'h0000);
    wait_done();

    // Zero error leaves the state untouched
    do_reset();
    en = 1'b1;
    do_arg(16'h0000, 16'h0000);
    wait_done();
    do_err(16'sh0000, 32'h0000_0000);
    wait_done();
    chk("zero_w0", 32'(dut.weights[0]), 0);
    chk("zero_w1", 32'(dut.weights[1]), 0);
    chk("zero_bias", 32'(dut.bias), 0);

    // One training step with full-scale inputs
    do_reset();
    en = 1'b1;
    do_arg(16'hffff, 16'h0000);
    wait_done();
    do_err(16'sh00ff, 32'h0000_0000);
    wait_done();
    chk("step_w0", 32'(dut.weights[0]), 127);
    chk("step_w1", 32'(dut.weights[1]), 127);
    chk("step_bias", 32'(dut.bias), 127);
    do_arg(16'hffff, 16'h017c);
    wait_done();

    // Feedback through weights with training disabled
    en = 1'b0;
    do_err(16'sh0100, 32'h007f_007f);
    wait_done();
    chk("noupd_w0", 32'(dut.weights[0]), 127);
    chk("noupd_w1", 32'(dut.weights[1]), 127);
    chk("noupd_bias", 32'(dut.bias), 127);

    // Simultaneous arg and err: err first, arg waits
    arg = 16'hffff;
    arg_valid = 1'b1;
    err = 16'sh0100;
    err_valid = 1'b1;
    exp_fbk.push_back(32'h007f_007f);
    exp_res.push_back(16'h017c);
    @(negedge clk);
    chk("simul_arg_ready", {31'b0, arg_ready}, 0);
    chk("simul_err_ready", {31'b0, err_ready}, 1);
    @(posedge clk);
    #1 err_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arg_ready && n < 50) begin n++; @(negedge clk); end
    if (!arg_ready) timeout("simul_arg");
    @(posedge clk);
    #1 arg_valid = 1'b0;
    wait_done();

    // Backpressure holds the result; reset mid-RES drops it
    res_ready = 1'b0;
    do_arg(16'h00ff, 16'h00fd);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, res_valid}, 1);
      chk("hold_res", {16'h0, res}, 32'h00fd);
      chk("hold_arg_ready", {31'b0, arg_ready}, 0);
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_res_valid", {31'b0, res_valid}, 0);
    chk("midrst_res", {16'h0, res}, 0);
    exp_res.delete();
    res_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Learn AND, then OR
    train_and_check("and_act", 0, 0, 0, 255);
    train_and_check("or_act", 0, 255, 255, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
